// File: rtl/tx_bank_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tx_bank_scheduler : two-bank ping-pong TX buffer scheduler with IFG     |
// |                     spacing and a read watchdog.                        |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module tx_bank_scheduler #(
  parameter int IFG_CYCLES = 48,
  parameter int RD_TIMEOUT = 1024
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_wr_req,
  input  logic       i_wr_done,
  input  logic       i_rd_done,
  output logic       o_wr_grant,
  output logic       o_wr_bank,
  output logic       o_rd_start,
  output logic       o_rd_bank,
  output logic [1:0] o_free_cnt,
  output logic       o_err,
  output logic       o_timeout
);

  localparam int GAP_W = $clog2((IFG_CYCLES > 2) ? IFG_CYCLES : 2) + 1;
  localparam int WD_W  = $clog2((RD_TIMEOUT > 2) ? RD_TIMEOUT : 2) + 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((RD_TIMEOUT > 1) ? RD_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    SENDING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_START  = 2'd1,
    RD_ACTIVE = 2'd2,
    RD_GAP    = 2'd3
  } rd_state_t;

  bank_state_t      bank [0:1];
  rd_state_t        rd_state;
  logic             wp;
  logic             rp;
  logic             req_q;
  logic             need_release;
  logic [GAP_W-1:0] gap_cnt;
  logic [WD_W-1:0]  wd_cnt;

  logic       any_filling;
  logic       fill_idx;
  logic       grant_ok;
  logic [1:0] free_now;

  // Only one bank can ever be FILLING, so a priority pick of the index is exact.
  assign any_filling = (bank[0] == FILLING) || (bank[1] == FILLING);
  assign fill_idx    = (bank[1] == FILLING);
  assign grant_ok    = req_q && !need_release && (bank[wp] == FREE) && !any_filling;
  assign free_now    = 2'(bank[0] == FREE) + 2'(bank[1] == FREE);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      bank[0]      <= FREE;
      bank[1]      <= FREE;
      rd_state     <= RD_IDLE;
      wp           <= 1'b0;
      rp           <= 1'b0;
      req_q        <= 1'b0;
      need_release <= 1'b0;
      gap_cnt      <= '0;
      wd_cnt       <= '0;
      o_wr_grant   <= 1'b0;
      o_wr_bank    <= 1'b0;
      o_rd_start   <= 1'b0;
      o_rd_bank    <= 1'b0;
      o_free_cnt   <= 2'd2;
      o_err        <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      req_q      <= i_wr_req;
      o_wr_grant <= 1'b0;
      o_rd_start <= 1'b0;
      o_free_cnt <= free_now;

      // A held request level is served once; it must be seen low before re-arming.
      if (!req_q) begin
        need_release <= 1'b0;
      end

      if (grant_ok) begin
        o_wr_grant   <= 1'b1;
        o_wr_bank    <= wp;
        bank[wp]     <= FILLING;
        wp           <= ~wp;
        need_release <= 1'b1;
      end

      if (i_wr_done) begin
        if (any_filling) begin
          bank[fill_idx] <= FULL;
        end else begin
          o_err <= 1'b1;
        end
      end

      if (i_rd_done && (rd_state != RD_ACTIVE)) begin
        o_err <= 1'b1;
      end

      case (rd_state)
        RD_IDLE: begin
          if (bank[rp] == FULL) begin
            rd_state <= RD_START;
          end
        end
        RD_START: begin
          o_rd_start <= 1'b1;
          o_rd_bank  <= rp;
          bank[rp]   <= SENDING;
          wd_cnt     <= '0;
          rd_state   <= RD_ACTIVE;
        end
        RD_ACTIVE: begin
          // The watchdog expiry is handled exactly like a completed read.
          if (i_rd_done || (wd_cnt >= WD_LAST)) begin
            if (!i_rd_done) begin
              o_timeout <= 1'b1;
            end
            bank[rp] <= FREE;
            rp       <= ~rp;
            gap_cnt  <= GAP_LOAD;
            rd_state <= (IFG_CYCLES == 0) ? RD_IDLE : RD_GAP;
          end else if (wd_cnt < WD_LAST) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        RD_GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            rd_state <= RD_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_bank_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_tx_bank_scheduler : directed scenarios plus randomized traffic       |
// |                        compared cycle by cycle with a timestamp model.  |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module tb_tx_bank_scheduler;

  localparam int IFG   = 48;
  localparam int RD_TO = 16;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wr_req = 1'b0;
  logic       i_wr_done = 1'b0;
  logic       i_rd_done = 1'b0;
  logic       o_wr_grant;
  logic       o_wr_bank;
  logic       o_rd_start;
  logic       o_rd_bank;
  logic [1:0] o_free_cnt;
  logic       o_err;
  logic       o_timeout;

  tx_bank_scheduler #(.IFG_CYCLES(IFG), .RD_TIMEOUT(RD_TO)) dut (
    .i_clock   (clk),
    .i_reset   (i_reset),
    .i_wr_req  (i_wr_req),
    .i_wr_done (i_wr_done),
    .i_rd_done (i_rd_done),
    .o_wr_grant(o_wr_grant),
    .o_wr_bank (o_wr_bank),
    .o_rd_start(o_rd_start),
    .o_rd_bank (o_rd_bank),
    .o_free_cnt(o_free_cnt),
    .o_err     (o_err),
    .o_timeout (o_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: bank codes 0 free, 1 filling, 2 full, 3 sending; reader kept as timestamps.
  int m_st[2];
  int m_wp, m_rp, m_req_prev, m_armed, m_busy, m_act, m_start_at, m_idle_from, m_n;
  int e_grant, e_wbank, e_start, e_rbank, e_free, e_err, e_to;

  task automatic model_reset();
    m_st[0] = 0; m_st[1] = 0;
    m_wp = 0; m_rp = 0; m_req_prev = 0; m_armed = 1;
    m_busy = 0; m_act = 0; m_start_at = -1; m_idle_from = 0;
    e_grant = 0; e_wbank = 0; e_start = 0; e_rbank = 0;
    e_free = 2; e_err = 0; e_to = 0;
  endtask

  task automatic model_edge();
    int snap[2];
    int filling;
    m_n++;
    snap = m_st;
    filling = (snap[0] == 1 || snap[1] == 1) ? 1 : 0;
    e_grant = 0;
    e_start = 0;
    e_free  = ((snap[0] == 0) ? 1 : 0) + ((snap[1] == 0) ? 1 : 0);
    if (m_req_prev == 1 && m_armed == 1 && snap[m_wp] == 0 && filling == 0) begin
      e_grant = 1; e_wbank = m_wp; m_st[m_wp] = 1; m_wp ^= 1; m_armed = 0;
    end
    if (m_req_prev == 0) m_armed = 1;
    m_req_prev = int'(i_wr_req);
    if (i_wr_done) begin
      if (filling == 1) m_st[(snap[1] == 1) ? 1 : 0] = 2;
      else e_err = 1;
    end
    if (m_start_at == m_n) begin
      e_start = 1; e_rbank = m_rp; m_st[m_rp] = 3; m_busy = 1; m_act = 0; m_start_at = -1;
      if (i_rd_done) e_err = 1;
    end else if (m_busy == 1) begin
      m_act++;
      if (i_rd_done || m_act == RD_TO) begin
        if (!i_rd_done) e_to = 1;
        m_st[m_rp] = 0; m_rp ^= 1; m_busy = 0; m_idle_from = m_n + IFG + 1;
      end
    end else begin
      if (i_rd_done) e_err = 1;
      if (m_start_at < 0 && snap[m_rp] == 2 && m_n >= m_idle_from) m_start_at = m_n + 1;
    end
  endtask

  task automatic compare_all();
    check("wr_grant", int'(o_wr_grant), e_grant);
    check("wr_bank",  int'(o_wr_bank),  e_wbank);
    check("rd_start", int'(o_rd_start), e_start);
    check("rd_bank",  int'(o_rd_bank),  e_rbank);
    check("free_cnt", int'(o_free_cnt), e_free);
    check("err",      int'(o_err),      e_err);
    check("timeout",  int'(o_timeout),  e_to);
  endtask

  task automatic step(input logic req, input logic wd, input logic rd);
    i_wr_req = req; i_wr_done = wd; i_rd_done = rd;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    i_wr_req = 1'b0; i_wr_done = 1'b0; i_rd_done = 1'b0;
    #2 i_reset = 1'b1;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 compare_all();
    i_reset = 1'b0;
  endtask

  task automatic wait_start(input logic req, input int budget, output int k);
    k = 0;
    while (!o_rd_start && k < budget) begin
      step(req, 1'b0, 1'b0);
      k++;
    end
    check("start_seen", int'(o_rd_start), 1);
  endtask

  task automatic write_frame();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int k, t, cnt;
    logic req, wd, rd;
    int fill_left, rd_left;

    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    check("reset_free_cnt", int'(o_free_cnt), 2);
    i_reset = 1'b0;

    // Single frame
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("sf_grant", int'(o_wr_grant), 1);
    check("sf_grant_bank", int'(o_wr_bank), 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    wait_start(1'b0, 5, k);
    check("sf_start_within_2", (k <= 2) ? 1 : 0, 1);
    check("sf_rd_bank", int'(o_rd_bank), 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("sf_free_after_done", int'(o_free_cnt), 2);
    cnt = 0;
    for (int i = 0; i < IFG; i++) begin
      step(1'b0, 1'b0, 1'b0);
      cnt += int'(o_rd_start);
    end
    check("sf_gap_quiet", cnt, 0);

    // Ping-pong with a withheld third request
    do_reset();
    write_frame();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("pp_grant1", int'(o_wr_grant), 1);
    check("pp_grant1_bank", int'(o_wr_bank), 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      cnt += int'(o_wr_grant);
    end
    check("pp_withheld", cnt, 0);
    check("pp_free_zero", int'(o_free_cnt), 0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("pp_grant_after_free", int'(o_wr_grant), 1);
    check("pp_grant_after_free_bank", int'(o_wr_bank), 0);
    wait_start(1'b0, 80, k);
    check("pp_gap_min", ((k + 1) >= IFG) ? 1 : 0, 1);
    check("pp_second_bank", int'(o_rd_bank), 1);

    // Protocol errors
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    check("err_spurious_wr", int'(o_err), 1);
    step(1'b0, 1'b0, 1'b0);
    check("err_wr_no_change", int'(o_free_cnt), 2);
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    check("err_spurious_rd", int'(o_err), 1);

    // Watchdog
    do_reset();
    write_frame();
    wait_start(1'b0, 5, k);
    t = 0;
    while (!o_timeout && t < 40) begin
      step(1'b0, 1'b0, 1'b0);
      t++;
    end
    check("wd_cycles", t, RD_TO);
    step(1'b0, 1'b0, 1'b0);
    check("wd_bank_freed", int'(o_free_cnt), 2);

    // Same-clock write done (bank 1) and read done (bank 0)
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("sim_grant_bank", int'(o_wr_bank), 1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("sim_free_one", int'(o_free_cnt), 1);
    check("sim_no_err", int'(o_err), 0);
    wait_start(1'b0, 80, k);
    check("sim_gap_min", ((k + 1) >= IFG) ? 1 : 0, 1);
    check("sim_rd_bank", int'(o_rd_bank), 1);

    // Reset while a read is active
    do_reset();
    write_frame();
    wait_start(1'b0, 5, k);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    do_reset();
    check("ract_free_cnt", int'(o_free_cnt), 2);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 1'b0);
      cnt += int'(o_rd_start);
    end
    check("ract_no_start", cnt, 0);

    // Randomized traffic
    do_reset();
    req = 1'b0; fill_left = -1; rd_left = -1;
    for (int c = 0; c < 4000; c++) begin
      wd = 1'b0; rd = 1'b0;
      if (o_wr_grant) begin
        fill_left = $urandom_range(0, 6);
        if ($urandom_range(0, 3) != 0) req = 1'b0;
      end else if (fill_left < 0) begin
        req = ($urandom_range(0, 9) < 6);
      end
      if (fill_left == 0) wd = 1'b1;
      if (fill_left >= 0) fill_left--;
      if (o_rd_start) rd_left = $urandom_range(1, 20);
      if (rd_left == 0) rd = 1'b1;
      if (rd_left >= 0) rd_left--;
      if ($urandom_range(0, 299) == 0) wd = 1'b1;
      if ($urandom_range(0, 299) == 0) rd = 1'b1;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        req = 1'b0; fill_left = -1; rd_left = -1;
      end else begin
        step(req, wd, rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_bank_scheduler.md
TX_BANK_SCHEDULER -- requirements
Module: tx_bank_scheduler

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 48, inter-frame gap in clocks (96 bit times at RMII 2 bits/clock).
REQ-002 SHALL have parameter RD_TIMEOUT, default 1024, maximum clocks a bank may stay in SENDING.
REQ-003 SHALL have port i_clock  input  1  50 MHz RMII clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_wr_req  input  1  level; frame writer requests a bank to fill.
REQ-006 SHALL have port i_wr_done  input  1  one-clock pulse; writer has finished filling the granted bank.
REQ-007 SHALL have port i_rd_done  input  1  one-clock pulse from the FIFO read controller; frame fully read.
REQ-008 SHALL have port o_wr_grant  output  1  one-clock pulse; bank granted to writer.
REQ-009 SHALL have port o_wr_bank  output  1  bank index granted by the latest o_wr_grant; held until the next grant.
REQ-010 SHALL have port o_rd_start  output  1  one-clock pulse; drives the read controller data-full input.
REQ-011 SHALL have port o_rd_bank  output  1  bank being read; forms the upper buffer address bit.
REQ-012 SHALL have port o_free_cnt  output  2  number of banks in FREE (0..2).
REQ-013 SHALL have port o_err  output  1  sticky protocol error flag.
REQ-014 SHALL have port o_timeout  output  1  sticky read watchdog flag.

Function
REQ-015 SHALL keep a 2-bit status per bank: FREE, FILLING, FULL or SENDING.
REQ-016 SHALL keep write pointer wp and read pointer rp (1 bit each); each toggles only on its own bank hand-off (strict ping-pong).
REQ-017 Grant: SHALL assert o_wr_grant one clock after a registered i_wr_req=1 while bank[wp]=FREE and no bank is FILLING; same edge sets bank[wp]=FILLING, o_wr_bank=wp, toggles wp.
REQ-018 SHALL withhold o_wr_grant while bank[wp] is not FREE; i_wr_req may stay high and is served when the bank frees; no queuing beyond the level.
REQ-019 SHALL require i_wr_req to be deasserted for at least one clock after a grant before a new grant is issued; no back-to-back grants on a held level.
REQ-020 On i_wr_done, SHALL set the FILLING bank to FULL; an i_wr_done with no FILLING bank SHALL be ignored and set o_err.
REQ-021 Read FSM states: RD_IDLE, RD_START, RD_ACTIVE, RD_GAP.
REQ-022 RD_IDLE -> RD_START when bank[rp]=FULL.
REQ-023 RD_START: SHALL pulse o_rd_start for one clock, set o_rd_bank=rp and bank[rp]=SENDING, clear the watchdog, go to RD_ACTIVE.
REQ-024 RD_ACTIVE, on i_rd_done: SHALL set bank[rp]=FREE, toggle rp, load the gap counter with IFG_CYCLES and go to RD_GAP; if IFG_CYCLES=0, go directly to RD_IDLE.
REQ-025 RD_GAP: SHALL decrement the gap counter each clock and go to RD_IDLE on the clock it reaches 1, so the gap is exactly IFG_CYCLES clocks with no o_rd_start.
REQ-026 i_rd_done outside RD_ACTIVE SHALL be ignored and set o_err.
REQ-027 Watchdog: SHALL count clocks in RD_ACTIVE; on reaching RD_TIMEOUT it SHALL act as i_rd_done (free bank, toggle rp, enter RD_GAP) and set o_timeout.
REQ-028 Simultaneous i_wr_done and i_rd_done SHALL both take effect in the same clock.
REQ-029 Status decisions SHALL use registered bank status; a bank freed at edge N is grantable at edge N+1 at the earliest.
REQ-030 o_free_cnt SHALL be a registered count of FREE banks, updated the clock after any status change.
REQ-031 Counter widths SHALL be ceil(log2(max(param,2))+1) bits; counters SHALL saturate, never wrap.

Reset
REQ-032 On i_reset, SHALL immediately set both banks FREE, wp=rp=0, read FSM to RD_IDLE, and all counters to 0.
REQ-033 Output reset values SHALL be: o_wr_grant=0, o_wr_bank=0, o_rd_start=0, o_rd_bank=0, o_free_cnt=2, o_err=0, o_timeout=0.
REQ-034 Reset mid-frame SHALL abandon the frame; after release, no o_rd_start until a new grant/done cycle completes.

Verification
REQ-035 Single frame: i_wr_req=1 -> o_wr_grant with bank 0; i_wr_done -> o_rd_start with o_rd_bank=0 within 2 clocks; i_rd_done -> o_free_cnt=2 and 48 clocks with no o_rd_start.
REQ-036 Ping-pong: two frames written back-to-back -> grants to banks 0 then 1, third request withheld (o_free_cnt=0) until the first i_rd_done; reads occur in order bank 0 then bank 1, starts spaced at least 48 clocks after each i_rd_done.
REQ-037 Protocol errors: spurious i_wr_done with no FILLING bank -> o_err=1 and no status change; spurious i_rd_done in RD_IDLE -> o_err=1.
REQ-038 Watchdog: with RD_TIMEOUT=16, withhold i_rd_done -> o_timeout=1 after 16 clocks in RD_ACTIVE and the bank returns to FREE.
REQ-039 Same-clock i_wr_done for bank 1 and i_rd_done for bank 0 -> bank 1 FULL, bank 0 FREE, o_rd_start for bank 1 after the gap.
REQ-040 Reset in RD_ACTIVE -> all outputs at reset values immediately, o_free_cnt=2, no o_rd_start after release.
